// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains the dual-clock byte FIFO read port and packs
// PACK entries per output word; partial words leave on flush or timeout.
//
// Ports:
//   rd_clk, n_rst        read-domain clock, async active-low reset
//   fifo_empty           FIFO empty flag
//   fifo_rd_en           FIFO pop request (combinational)
//   fifo_dout            FIFO data, valid the cycle after a pop
//   flush                pulse: emit any partial word
//   m_valid/m_ready      output word handshake
//   m_data, m_keep       packed word, lane-valid mask (lane 0 = oldest)
//   busy                 bytes held, pop pending or word waiting
module fifo_rd_packer #(
  parameter int FIFO_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                       rd_clk,
  input  logic                       n_rst,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0]      fifo_dout,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [PACK*FIFO_WIDTH-1:0] m_data,
  output logic [PACK-1:0]            m_keep,
  output logic                       busy
);

  localparam int W  = FIFO_WIDTH;
  localparam int DW = PACK * FIFO_WIDTH;
  localparam int CW = $clog2(PACK);
  localparam int IW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW:0]   SUM_LAST = (CW+1)'(PACK - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PACK - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  typedef enum logic {
    FILL,
    FLUSH
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [DW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_pend;
  logic [IW-1:0]   r_idle;
  logic            r_m_valid;
  logic [DW-1:0]   r_m_data;
  logic [PACK-1:0] r_m_keep;

  logic            w_slot_free;
  logic [CW:0]     w_sum;
  logic            w_last;
  logic            w_done_now;
  logic            w_flush_req;
  logic            w_pop;
  logic            w_full_ld;
  logic            w_flush_go;
  logic            w_part_ld;
  logic            w_tmo;
  logic [IW-1:0]   w_idle_nxt;
  logic [DW-1:0]   w_cap_word;
  logic [DW-1:0]   w_part_word;
  logic [PACK-1:0] w_part_keep;

  always_comb begin
    w_slot_free = !r_m_valid || m_ready;
    w_sum       = {1'b0, r_cnt} + {{CW{1'b0}}, r_pend};
    w_last      = (r_cnt == CNT_LAST);
    w_done_now  = r_pend && w_last && w_slot_free;
    w_flush_req = (r_state == FLUSH);
    // A pop that lands in the top lane is only issued when the
    // output slot is free now; nothing else can load the slot in
    // between, so the completing capture always finds it empty.
    w_pop = !fifo_empty && !w_flush_req &&
            ((w_sum < SUM_LAST) ||
             ((w_sum == SUM_LAST) && w_slot_free) ||
             w_done_now);
    w_full_ld   = r_pend && w_last;
    w_flush_go  = w_flush_req && !r_pend && w_slot_free;
    w_part_ld   = w_flush_go && (r_cnt != '0);
    w_tmo       = (TIMEOUT > 0) && (r_idle == IDLE_MAX) &&
                  (r_cnt != '0);
  end

  always_comb begin
    w_cap_word = r_acc;
    w_cap_word[int'(r_cnt)*W +: W] = fifo_dout;
    w_part_word = '0;
    w_part_keep = '0;
    for (int i = 0; i < PACK; i++) begin
      if (CW'(i) < r_cnt) begin
        w_part_word[i*W +: W] = r_acc[i*W +: W];
        w_part_keep[i]        = 1'b1;
      end
    end
  end

  always_comb begin
    w_idle_nxt = r_idle;
    if (r_pend || w_flush_go) begin
      w_idle_nxt = '0;
    end else if ((r_cnt != '0) && !w_pop &&
                 (r_idle != IDLE_MAX)) begin
      w_idle_nxt = r_idle + IW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FILL: begin
        if (flush || w_tmo) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (w_flush_go) begin
          w_state_nxt = FILL;
        end
      end
    endcase
  end

  always_ff @(posedge rd_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge rd_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_pend    <= 1'b0;
      r_idle    <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_keep  <= '0;
    end else begin
      r_pend <= w_pop;
      r_idle <= w_idle_nxt;
      if (r_pend) begin
        r_acc <= w_cap_word;
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      end else if (w_part_ld) begin
        r_cnt <= '0;
      end
      if (w_full_ld) begin
        r_m_data  <= w_cap_word;
        r_m_keep  <= '1;
        r_m_valid <= 1'b1;
      end else if (w_part_ld) begin
        r_m_data  <= w_part_word;
        r_m_keep  <= w_part_keep;
        r_m_valid <= 1'b1;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign fifo_rd_en = w_pop;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_keep     = r_m_keep;
  assign busy       = (r_cnt != '0) || r_pend || r_m_valid;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: scenario tasks plus a randomized run scoreboarded
// against the pushed byte stream; FIFO modelled as a queue.
`timescale 1ns/1ps
module tb_fifo_rd_packer;

  localparam int W   = 8;
  localparam int P   = 4;
  localparam int TMO = 16;

  logic          rd_clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_dout = '0;
  logic          flush = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [31:0]   m_data;
  logic [3:0]    m_keep;
  logic          busy;

  int            vecs = 0;
  int            errs = 0;
  logic [7:0]    fq[$];
  logic          hold = 1'b0;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_packer #(
    .FIFO_WIDTH(W),
    .PACK(P),
    .TIMEOUT(TMO)
  ) dut (
    .rd_clk(rd_clk),
    .n_rst(n_rst),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout),
    .flush(flush),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_keep(m_keep),
    .busy(busy)
  );

  // registered-read FIFO: data appears the cycle after the pop
  always @(posedge rd_clk) begin
    if (n_rst && fifo_rd_en && !fifo_empty && fq.size() > 0)
      fifo_dout <= fq.pop_front();
  end

  task automatic settle();
    fifo_empty = hold || (fq.size() == 0);
    #1;
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    settle();
    tick();
    tick();
    settle();
    vecs++;
    if (m_valid !== 1'b0 || m_data !== 32'h0 ||
        m_keep !== 4'h0 || busy !== 1'b0 ||
        fifo_rd_en !== 1'b0) begin
      errs++;
      $display("FAIL reset: v=%b d=%h k=%h busy=%b rd=%b want 0",
               m_valid, m_data, m_keep, busy, fifo_rd_en);
    end
    n_rst = 1'b1;
    settle();
    tick();
    settle();
    vecs++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: v=%b busy=%b want 0 0",
               m_valid, busy);
    end
  endtask

  task automatic test_stream();
    logic [31:0] wd[$];
    logic [3:0]  wk[$];
    int run = 0;
    int best = 0;
    int pops = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'h11 * (i + 1)));
    for (int c = 0; c < 20; c++) begin
      settle();
      if (fifo_rd_en) begin
        pops++;
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
      if (m_valid && m_ready) begin
        wd.push_back(m_data);
        wk.push_back(m_keep);
      end
      tick();
    end
    vecs++;
    if (best != 8 || pops != 8) begin
      errs++;
      $display("FAIL stream_rd_en: run=%0d pops=%0d want 8 8",
               best, pops);
    end
    vecs++;
    if (wd.size() != 2 || wd[0] !== 32'h44332211 ||
        wk[0] !== 4'hF) begin
      errs++;
      $display("FAIL stream_w0: n=%0d d=%h k=%h want 2 44332211 f",
               wd.size(), wd.size() > 0 ? wd[0] : 32'h0,
               wk.size() > 0 ? wk[0] : 4'h0);
    end
    vecs++;
    if (wd.size() < 2 || wd[1] !== 32'h88776655 ||
        wk[1] !== 4'hF) begin
      errs++;
      $display("FAIL stream_w1: d=%h want 88776655 keep f",
               wd.size() > 1 ? wd[1] : 32'h0);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  b[12];
    logic [31:0] ex[3];
    logic [31:0] wd[$];
    int pops = 0;
    int bad = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      b[i] = 8'($urandom);
      fq.push_back(b[i]);
    end
    for (int j = 0; j < 3; j++)
      ex[j] = {b[4*j+3], b[4*j+2], b[4*j+1], b[4*j]};
    for (int c = 0; c < 16; c++) begin
      settle();
      if (fifo_rd_en) pops++;
      if (m_valid) begin
        vecs++;
        if (m_data !== ex[0] || m_keep !== 4'hF) begin
          errs++;
          bad++;
          if (bad < 4)
            $display("FAIL bp_hold: d=%h k=%h want %h f",
                     m_data, m_keep, ex[0]);
        end
      end
      tick();
    end
    settle();
    vecs++;
    if (pops != 7 || m_valid !== 1'b1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL bp_stall: pops=%0d v=%b busy=%b want 7 1 1",
               pops, m_valid, busy);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      settle();
      if (m_valid && m_ready) begin
        wd.push_back(m_data);
        vecs++;
        if (m_keep !== 4'hF) begin
          errs++;
          $display("FAIL bp_keep: k=%h want f", m_keep);
        end
      end
      tick();
    end
    vecs++;
    if (wd.size() != 3 || wd[0] !== ex[0] ||
        wd[1] !== ex[1] || wd[2] !== ex[2] || fq.size() != 0) begin
      errs++;
      $display("FAIL bp_order: n=%0d left=%0d want 3 words %h %h %h",
               wd.size(), fq.size(), ex[0], ex[1], ex[2]);
    end
  endtask

  task automatic test_timeout();
    int first = -1;
    int nw = 0;
    logic [31:0] d = '0;
    logic [3:0]  k = '0;
    m_ready = 1'b1;
    fq.push_back(8'hA1);
    fq.push_back(8'hB2);
    fq.push_back(8'hC3);
    for (int c = 0; c < 40; c++) begin
      settle();
      if (m_valid) begin
        nw++;
        if (first < 0) begin
          first = c;
          d = m_data;
          k = m_keep;
        end
      end
      tick();
    end
    vecs++;
    if (first != 22 || nw != 1) begin
      errs++;
      $display("FAIL timeout_time: at=%0d n=%0d want 22 1",
               first, nw);
    end
    vecs++;
    if (d !== 32'h00C3B2A1 || k !== 4'h7) begin
      errs++;
      $display("FAIL timeout_word: d=%h k=%h want 00c3b2a1 7",
               d, k);
    end
  endtask

  task automatic test_flush_race();
    logic [7:0]  b[4];
    logic [31:0] d = '0;
    logic [3:0]  k = '0;
    int nw = 0;
    int first = -1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      fq.push_back(b[i]);
    end
    for (int c = 0; c < 12; c++) begin
      flush = (c == 4);
      settle();
      if (m_valid && m_ready) begin
        nw++;
        d = m_data;
        k = m_keep;
      end
      tick();
    end
    flush = 1'b0;
    vecs++;
    if (nw != 1 || d !== {b[3], b[2], b[1], b[0]} ||
        k !== 4'hF) begin
      errs++;
      $display("FAIL flush_race: n=%0d d=%h k=%h want 1 %h f",
               nw, d, k, {b[3], b[2], b[1], b[0]});
    end
    nw = 0;
    for (int c = 0; c < 10; c++) begin
      flush = (c == 0);
      settle();
      if (m_valid) nw++;
      tick();
    end
    flush = 1'b0;
    settle();
    vecs++;
    if (nw != 0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL flush_empty: words=%0d busy=%b want 0 0",
               nw, busy);
    end
    nw = 0;
    fq.push_back(b[0]);
    fq.push_back(b[1]);
    for (int c = 0; c < 12; c++) begin
      flush = (c == 3);
      settle();
      if (m_valid) begin
        nw++;
        if (first < 0) begin
          first = c;
          d = m_data;
          k = m_keep;
        end
      end
      tick();
    end
    flush = 1'b0;
    vecs++;
    if (first != 5 || nw != 1 || k !== 4'h3 ||
        d !== {16'h0, b[1], b[0]}) begin
      errs++;
      $display("FAIL flush_part: at=%0d n=%0d d=%h k=%h want 5 1 %h 3",
               first, nw, d, k, {16'h0, b[1], b[0]});
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  b[4];
    logic [31:0] d = '0;
    logic [3:0]  k = '0;
    int nw = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) fq.push_back(8'($urandom));
    for (int c = 0; c < 10; c++) begin
      settle();
      tick();
    end
    settle();
    vecs++;
    if (m_valid !== 1'b1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL rst_pre: v=%b busy=%b want 1 1",
               m_valid, busy);
    end
    n_rst = 1'b0;
    #1;
    vecs++;
    if (m_valid !== 1'b0 || m_data !== 32'h0 ||
        m_keep !== 4'h0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_async: v=%b d=%h k=%h busy=%b want 0",
               m_valid, m_data, m_keep, busy);
    end
    fq.delete();
    settle();
    tick();
    n_rst = 1'b1;
    settle();
    tick();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      fq.push_back(b[i]);
    end
    for (int c = 0; c < 14; c++) begin
      settle();
      if (m_valid && m_ready) begin
        nw++;
        d = m_data;
        k = m_keep;
      end
      tick();
    end
    vecs++;
    if (nw != 1 || d !== {b[3], b[2], b[1], b[0]} ||
        k !== 4'hF) begin
      errs++;
      $display("FAIL rst_clean: n=%0d d=%h k=%h want 1 %h f",
               nw, d, k, {b[3], b[2], b[1], b[0]});
    end
  endtask

  task automatic test_random();
    logic [7:0]  ex[$];
    logic [7:0]  bt;
    logic        pstall = 1'b0;
    logic [31:0] pd = '0;
    logic [3:0]  pk = '0;
    logic        ok;
    int pushed = 0;
    int c = 0;
    int k;
    int bad = 0;
    while ((pushed < 10000 || ex.size() > 0) && c < 70000) begin
      if (pushed < 10000 && fq.size() < 6 &&
          $urandom_range(0, 3) != 0) begin
        bt = 8'($urandom);
        fq.push_back(bt);
        ex.push_back(bt);
        pushed++;
      end
      hold    = ($urandom_range(0, 3) == 0);
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 49) == 0);
      settle();
      if (pstall) begin
        vecs++;
        if (m_valid !== 1'b1 || m_data !== pd || m_keep !== pk) begin
          errs++;
          bad++;
          if (bad < 8)
            $display("FAIL rnd_hold: v=%b d=%h k=%h want 1 %h %h",
                     m_valid, m_data, m_keep, pd, pk);
        end
      end
      if (m_valid && m_ready) begin
        k  = $countones(m_keep);
        ok = (k >= 1) && (k <= ex.size()) &&
             (m_keep == 4'((1 << k) - 1));
        for (int i = 0; i < 4; i++) begin
          if (ok) begin
            if (i < k) begin
              if (m_data[i*8 +: 8] !== ex[i]) ok = 1'b0;
            end else if (m_data[i*8 +: 8] !== 8'h00) begin
              ok = 1'b0;
            end
          end
        end
        vecs++;
        if (!ok) begin
          errs++;
          bad++;
          if (bad < 8)
            $display("FAIL rnd_word: d=%h k=%h want next %0d of %0d",
                     m_data, m_keep, k, ex.size());
        end
        for (int i = 0; i < k; i++)
          if (ex.size() > 0) void'(ex.pop_front());
      end
      pstall = m_valid && !m_ready;
      pd = m_data;
      pk = m_keep;
      tick();
      c++;
    end
    hold = 1'b0;
    flush = 1'b0;
    vecs++;
    if (ex.size() != 0 || pushed != 10000) begin
      errs++;
      $display("FAIL rnd_drain: left=%0d pushed=%0d cyc=%0d want 0",
               ex.size(), pushed, c);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_timeout();
    test_flush_race();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
